// File: rtl/safety_fault_pkg.sv
// Shared types and constants for the safety fault collector.
// Optional feature macro used by the top: SAFETY_FAULT_INJECT_EN.
package safety_fault_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_WARN      = 2'd1,
        ST_SAFE      = 2'd2,
        ST_RESET_REQ = 2'd3
    } fault_state_e;

    localparam logic [7:0] CODE_NONE     = 8'h00;
    localparam logic [7:0] CODE_LOCKSTEP = 8'h01;
    localparam logic [7:0] CODE_UE       = 8'h02;
    localparam logic [7:0] CODE_WDG      = 8'h03;
    localparam logic [7:0] CODE_CE       = 8'h04;
    localparam logic [7:0] CODE_BUS      = 8'h05;
    localparam logic [7:0] CODE_INJECT   = 8'h06;

    localparam int ECC_CE_BIT     = 0;
    localparam int ECC_UE_BIT     = 1;
    localparam int ECC_REGION_LSB = 2;
    localparam int ECC_REGION_MSB = 5;

    // Any response code with the MSB set is a bus error.
    localparam logic [1:0] RESP_ERR = 2'b10;

    // Saturating 16-bit increment used by the CE event counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : (v + 16'h0001);
    endfunction

endpackage

// File: rtl/safety_leaky_cnt.sv
// Saturating leaky-bucket counter: adds 0..2 per cycle, removes 1 every
// LEAK_PERIOD cycles when nonzero. A leak that coincides with an increment is
// held back one cycle (and again, as long as increments keep arriving).
module safety_leaky_cnt
    import safety_fault_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int LEAK_PERIOD = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    localparam int TMR_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LEAK_PERIOD - 1);
    localparam logic [CNT_W:0]   CNT_MAX  = {1'b0, {CNT_W{1'b1}}};

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             leak_due_s;
    logic [CNT_W:0]   sum_s;

    // Leak timer, deferred-leak flag and bucket next-state.
    always_comb begin
        tmr_d      = (tmr_q == TMR_LAST) ? '0 : (tmr_q + 1'b1);
        leak_due_s = (tmr_q == TMR_LAST) || pend_q;
        sum_s      = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc};
        cnt_d      = cnt_q;
        pend_d     = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (inc != 2'b00) begin
            cnt_d  = (sum_s > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_s[CNT_W-1:0];
            pend_d = leak_due_s;
        end else if (leak_due_s && (cnt_q != '0)) begin
            cnt_d  = cnt_q - 1'b1;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/safety_fault_collector.sv
// Safety fault collector: classifies island fault events, runs the
// NORMAL/WARN/SAFE/RESET_REQ escalation FSM and latches the first fault code.
// Define SAFETY_FAULT_INJECT_EN to add the inject_vld/inject_sel test inputs.
module safety_fault_collector
    import safety_fault_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int WARN_THRESH = 4,
    parameter int SAFE_THRESH = 8,
    parameter int LEAK_PERIOD = 256,
    parameter int FTTI_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        ready,
    input  logic [1:0]  resp,
    input  logic        error,
    input  logic        lockstep_match,
    input  logic [5:0]  ecc_status,
    input  logic        wdg_timeout,
    input  logic        fault_clr,
`ifdef SAFETY_FAULT_INJECT_EN
    input  logic        inject_vld,
    input  logic [1:0]  inject_sel,
`endif
    output logic [1:0]  fault_state,
    output logic        fault_irq,
    output logic        safe_state_req,
    output logic        reset_req,
    output logic [7:0]  fault_code,
    output logic [3:0]  fault_region,
    output logic [15:0] ce_count
);

    localparam int FT_W = (FTTI_CYCLES > 1) ? $clog2(FTTI_CYCLES) : 1;
    localparam logic [FT_W-1:0]  FTTI_LAST = FT_W'(FTTI_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARN_LVL  = CNT_W'(WARN_THRESH);
    localparam logic [CNT_W-1:0] SAFE_LVL  = CNT_W'(SAFE_THRESH);

    fault_state_e     state_q, state_d;
    logic [FT_W-1:0]  ftti_q, ftti_d;
    logic             irq_q, irq_d;
    logic             safe_q, safe_d;
    logic             rreq_q, rreq_d;
    logic [7:0]       code_q, code_d;
    logic [3:0]       region_q, region_d;
    logic [15:0]      ce_cnt_q, ce_cnt_d;

    logic inj_ls_s, inj_ue_s, inj_wdg_s, inj_ce_s;
    logic ls_real_s, ue_real_s, wdg_real_s, ce_real_s, bus_real_s;
    logic ls_any_s, ue_any_s, wdg_any_s, ce_any_s;
    logic crit_s, clr_acc_s, cnt_clr_s, new_ecc_s;
    logic [1:0]       inc_s;
    logic [7:0]       new_code_s;
    logic [CNT_W-1:0] minor_cnt_s;

`ifdef SAFETY_FAULT_INJECT_EN
    // Decode the injected event onto one of the four fault sources.
    always_comb begin
        inj_ls_s  = inject_vld && (inject_sel == 2'd0);
        inj_ue_s  = inject_vld && (inject_sel == 2'd1);
        inj_wdg_s = inject_vld && (inject_sel == 2'd2);
        inj_ce_s  = inject_vld && (inject_sel == 2'd3);
    end
`else
    // No injection hardware: injected sources are permanently idle.
    always_comb begin
        inj_ls_s  = 1'b0;
        inj_ue_s  = 1'b0;
        inj_wdg_s = 1'b0;
        inj_ce_s  = 1'b0;
    end
`endif

    // Classify this cycle's events into critical / minor and pick the code
    // that would be latched if this were the first fault.
    always_comb begin
        ls_real_s  = !lockstep_match;
        ue_real_s  = ecc_status[ECC_UE_BIT];
        wdg_real_s = wdg_timeout;
        ce_real_s  = ecc_status[ECC_CE_BIT];
        bus_real_s = (valid && ready && (|(resp & RESP_ERR))) || error;
        ls_any_s   = ls_real_s  || inj_ls_s;
        ue_any_s   = ue_real_s  || inj_ue_s;
        wdg_any_s  = wdg_real_s || inj_wdg_s;
        ce_any_s   = ce_real_s  || inj_ce_s;
        crit_s     = ls_any_s || ue_any_s || wdg_any_s;
        inc_s      = {1'b0, ce_any_s} + {1'b0, bus_real_s};
        new_ecc_s  = 1'b0;
        if (ls_any_s) begin
            new_code_s = ls_real_s ? CODE_LOCKSTEP : CODE_INJECT;
        end else if (ue_any_s) begin
            new_code_s = ue_real_s ? CODE_UE : CODE_INJECT;
            new_ecc_s  = ue_real_s;
        end else if (wdg_any_s) begin
            new_code_s = wdg_real_s ? CODE_WDG : CODE_INJECT;
        end else if (bus_real_s) begin
            new_code_s = CODE_BUS;
        end else if (ce_any_s) begin
            new_code_s = ce_real_s ? CODE_CE : CODE_INJECT;
            new_ecc_s  = ce_real_s;
        end else begin
            new_code_s = CODE_NONE;
        end
    end

    safety_leaky_cnt #(
        .CNT_W       (CNT_W),
        .LEAK_PERIOD (LEAK_PERIOD)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .inc (inc_s),
        .cnt (minor_cnt_s)
    );

    // Escalation FSM next state, FTTI timer and clear acceptance.
    always_comb begin
        state_d   = state_q;
        ftti_d    = ftti_q;
        clr_acc_s = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                ftti_d = '0;
                if (crit_s || (minor_cnt_s >= SAFE_LVL)) begin
                    state_d = ST_SAFE;
                end else begin
                    state_d   = (minor_cnt_s >= WARN_LVL) ? ST_WARN : ST_NORMAL;
                    clr_acc_s = fault_clr;
                end
            end
            ST_WARN: begin
                ftti_d = '0;
                if (crit_s || (minor_cnt_s >= SAFE_LVL)) begin
                    state_d = ST_SAFE;
                end else if (fault_clr) begin
                    state_d   = ST_NORMAL;
                    clr_acc_s = 1'b1;
                end else begin
                    state_d = ST_WARN;
                end
            end
            ST_SAFE: begin
                // Expiry beats a same-cycle clear; critical events never restart the timer.
                if (ftti_q == FTTI_LAST) begin
                    state_d = ST_RESET_REQ;
                end else if (fault_clr && !crit_s) begin
                    state_d   = ST_NORMAL;
                    ftti_d    = '0;
                    clr_acc_s = 1'b1;
                end else begin
                    state_d = ST_SAFE;
                    ftti_d  = ftti_q + 1'b1;
                end
            end
            ST_RESET_REQ: begin
                state_d = ST_RESET_REQ;
            end
            default: begin
                state_d = ST_NORMAL;
                ftti_d  = '0;
            end
        endcase
        cnt_clr_s = clr_acc_s && (state_q != ST_NORMAL);
    end

    // Output next-state: first-fault capture, CE tally and state-derived requests.
    always_comb begin
        code_d   = code_q;
        region_d = region_q;
        if (clr_acc_s) begin
            code_d   = CODE_NONE;
            region_d = 4'h0;
        end else if ((code_q == CODE_NONE) && (new_code_s != CODE_NONE)) begin
            code_d   = new_code_s;
            region_d = new_ecc_s ? ecc_status[ECC_REGION_MSB:ECC_REGION_LSB] : region_q;
        end else begin
            code_d   = code_q;
            region_d = region_q;
        end
        ce_cnt_d = ce_any_s ? sat_inc16(ce_cnt_q) : ce_cnt_q;
        irq_d    = (state_d != state_q) && (state_d != ST_NORMAL);
        safe_d   = (state_d == ST_SAFE);
        rreq_d   = (state_d == ST_RESET_REQ);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_NORMAL;
            ftti_q   <= '0;
            irq_q    <= 1'b0;
            safe_q   <= 1'b0;
            rreq_q   <= 1'b0;
            code_q   <= 8'h00;
            region_q <= 4'h0;
            ce_cnt_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            ftti_q   <= ftti_d;
            irq_q    <= irq_d;
            safe_q   <= safe_d;
            rreq_q   <= rreq_d;
            code_q   <= code_d;
            region_q <= region_d;
            ce_cnt_q <= ce_cnt_d;
        end
    end

    assign fault_state    = state_q;
    assign fault_irq      = irq_q;
    assign safe_state_req = safe_q;
    assign reset_req      = rreq_q;
    assign fault_code     = code_q;
    assign fault_region   = region_q;
    assign ce_count       = ce_cnt_q;

endmodule

// File: tb/tb_safety_fault_collector.sv
// Directed bench for safety_fault_collector: a vector table for single-cycle
// behaviour plus hand-written sequences for FTTI expiry, SAFE clear and leaks.
module tb_safety_fault_collector;

    logic        clk;
    logic        rst;
    logic        valid, ready, error, lockstep_match, wdg_timeout, fault_clr;
    logic [1:0]  resp;
    logic [5:0]  ecc_status;
    logic [1:0]  fault_state;
    logic        fault_irq, safe_state_req, reset_req;
    logic [7:0]  fault_code;
    logic [3:0]  fault_region;
    logic [15:0] ce_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    safety_fault_collector dut (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .ready          (ready),
        .resp           (resp),
        .error          (error),
        .lockstep_match (lockstep_match),
        .ecc_status     (ecc_status),
        .wdg_timeout    (wdg_timeout),
        .fault_clr      (fault_clr),
        .fault_state    (fault_state),
        .fault_irq      (fault_irq),
        .safe_state_req (safe_state_req),
        .reset_req      (reset_req),
        .fault_code     (fault_code),
        .fault_region   (fault_region),
        .ce_count       (ce_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ls;
        logic [5:0]  ecc;
        logic        wdg;
        logic        vld;
        logic        rdy;
        logic [1:0]  rsp;
        logic        err;
        logic        clr;
        logic [1:0]  st;
        logic        irq;
        logic        safe;
        logic        rr;
        logic [7:0]  code;
        logic [3:0]  rgn;
        logic [15:0] ce;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic ls, logic [5:0] ecc, logic wdg, logic vld, logic rdy,
                                logic [1:0] rsp, logic err, logic clr, logic [1:0] st,
                                logic irq, logic safe, logic rr, logic [7:0] code,
                                logic [3:0] rgn, logic [15:0] ce);
        vec_t v;
        v.ls = ls; v.ecc = ecc; v.wdg = wdg; v.vld = vld; v.rdy = rdy; v.rsp = rsp;
        v.err = err; v.clr = clr; v.st = st; v.irq = irq; v.safe = safe; v.rr = rr;
        v.code = code; v.rgn = rgn; v.ce = ce;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        valid = 1'b0; ready = 1'b0; resp = 2'b00; error = 1'b0;
        lockstep_match = 1'b1; ecc_status = 6'h00; wdg_timeout = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic irq,
                           input logic safe, input logic rr, input logic [7:0] code);
        chk({tag, "_state"}, {30'd0, fault_state}, {30'd0, st});
        chk({tag, "_irq"},   {31'd0, fault_irq},   {31'd0, irq});
        chk({tag, "_safe"},  {31'd0, safe_state_req}, {31'd0, safe});
        chk({tag, "_rreq"},  {31'd0, reset_req},   {31'd0, rr});
        chk({tag, "_code"},  {24'd0, fault_code},  {24'd0, code});
    endtask

    initial begin
        // Walk through CE->WARN, clears, lockstep->SAFE, UE+clear, UE+wdg region capture, bus errors.
        vecs[0]  = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd0);
        vecs[1]  = mk(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h04, 4'h0, 16'd1);
        vecs[2]  = mk(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h04, 4'h0, 16'd2);
        vecs[3]  = mk(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h04, 4'h0, 16'd3);
        vecs[4]  = mk(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h04, 4'h0, 16'd4);
        vecs[5]  = mk(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'h04, 4'h0, 16'd5);
        vecs[6]  = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'h04, 4'h0, 16'd5);
        vecs[7]  = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd5);
        vecs[8]  = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd5);
        vecs[9]  = mk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'h01, 4'h0, 16'd5);
        vecs[10] = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'h01, 4'h0, 16'd5);
        vecs[11] = mk(1'b1, 6'h02, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 8'h01, 4'h0, 16'd5);
        vecs[12] = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd5);
        vecs[13] = mk(1'b1, 6'h2A, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'h02, 4'hA, 16'd5);
        vecs[14] = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd5);
        vecs[15] = mk(1'b1, 6'h00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0, 16'd5);
        vecs[16] = mk(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0, 16'd5);
        vecs[17] = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd5);
        vecs[18] = mk(1'b1, 6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0, 16'd6);
        vecs[19] = mk(1'b1, 6'h3D, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0, 16'd7);
        vecs[20] = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'h05, 4'h0, 16'd7);
        vecs[21] = mk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'h05, 4'h0, 16'd7);

        do_reset();
        chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_region", {28'd0, fault_region}, 32'd0);
        chk("reset_ce", {16'd0, ce_count}, 32'd0);

        for (int i = 0; i < 22; i++) begin
            lockstep_match = vecs[i].ls;  ecc_status = vecs[i].ecc; wdg_timeout = vecs[i].wdg;
            valid = vecs[i].vld; ready = vecs[i].rdy; resp = vecs[i].rsp;
            error = vecs[i].err; fault_clr = vecs[i].clr;
            step();
            chk_out($sformatf("v%0d", i), vecs[i].st, vecs[i].irq, vecs[i].safe, vecs[i].rr, vecs[i].code);
            chk($sformatf("v%0d_region", i), {28'd0, fault_region}, {28'd0, vecs[i].rgn});
            chk($sformatf("v%0d_ce", i), {16'd0, ce_count}, {16'd0, vecs[i].ce});
        end

        // FTTI expiry from WARN: SAFE for exactly 1000 cycles, then sticky RESET_REQ.
        idle();
        lockstep_match = 1'b0;
        step();
        chk_out("ftti_enter", 2'd2, 1'b1, 1'b1, 1'b0, 8'h05);
        idle();
        for (int k = 0; k < 999; k++) step();
        chk_out("ftti_last_safe", 2'd2, 1'b0, 1'b1, 1'b0, 8'h05);
        step();
        chk_out("ftti_expire", 2'd3, 1'b1, 1'b0, 1'b1, 8'h05);
        step();
        chk_out("rreq_hold", 2'd3, 1'b0, 1'b0, 1'b1, 8'h05);
        fault_clr = 1'b1;
        step();
        chk_out("rreq_clr_ign", 2'd3, 1'b0, 1'b0, 1'b1, 8'h05);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        chk_out("rreq_rst", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rreq_rst_ce", {16'd0, ce_count}, 32'd0);

        // SAFE cleared at cycle 500 of the FTTI window, with minor count pending.
        idle();
        lockstep_match = 1'b0;
        step();
        chk_out("safe_enter", 2'd2, 1'b1, 1'b1, 1'b0, 8'h01);
        for (int c = 2; c <= 499; c++) begin
            idle();
            ecc_status = (c >= 498) ? 6'h01 : 6'h00;
            step();
        end
        chk("safe_cnt_pre", {28'd0, dut.minor_cnt_s}, 32'd2);
        chk_out("safe_pre_clr", 2'd2, 1'b0, 1'b1, 1'b0, 8'h01);
        idle();
        fault_clr = 1'b1;
        step();
        chk_out("safe_clr", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("safe_clr_cnt", {28'd0, dut.minor_cnt_s}, 32'd0);
        chk("safe_clr_ce", {16'd0, ce_count}, 32'd2);

        // Leaky bucket: drains after 768 idle cycles; leak deferred by a coincident CE.
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            idle(); ecc_status = 6'h01; step();
        end
        idle();
        chk("leak_cnt3", {28'd0, dut.minor_cnt_s}, 32'd3);
        while (cyc < 256) step();
        chk("leak_cnt2", {28'd0, dut.minor_cnt_s}, 32'd2);
        while (cyc < 768) step();
        chk("leak_cnt0", {28'd0, dut.minor_cnt_s}, 32'd0);
        while (cyc < 999) step();
        ecc_status = 6'h01;
        step();
        step();
        idle();
        chk("leak_pre", {28'd0, dut.minor_cnt_s}, 32'd2);
        while (cyc < 1023) step();
        ecc_status = 6'h01;
        step();
        idle();
        chk("leak_defer_inc", {28'd0, dut.minor_cnt_s}, 32'd3);
        step();
        chk("leak_defer_dec", {28'd0, dut.minor_cnt_s}, 32'd2);
        step();
        chk("leak_after", {28'd0, dut.minor_cnt_s}, 32'd2);
        chk("leak_ce", {16'd0, ce_count}, 32'd6);

        // Double minor events per cycle drive the count to SAFE_THRESH.
        for (int k = 0; k < 3; k++) begin
            idle(); ecc_status = 6'h01; error = 1'b1; step();
            if (k == 1) chk_out("cnt_warn", 2'd1, 1'b1, 1'b0, 1'b0, 8'h04);
        end
        idle();
        step();
        chk_out("cnt_safe", 2'd2, 1'b1, 1'b1, 1'b0, 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
